display_scan_driver: RTL and testbench
======================================

# display_scan_driver

Time-multiplexed scan driver placed directly upstream of the BCD-to-seven-segment decoder. It holds a multi-digit packed BCD word in a double buffer and steps through the digit positions at a programmable rate. For each position it presents one 4-bit BCD code to the decoder and drives the matching active-low digit-select line. It also provides leading-zero blanking, whole-display blanking, an anti-ghosting dead cycle and a frame-complete pulse.

## Interface
- NUM_DIGITS, 8: number of multiplexed digit positions; legal range 2..8.
- SCAN_DIV, 1000: clock cycles per digit slot; minimum 2.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- load  in  1  one-cycle strobe that captures bcd_in into the pending buffer.
- bcd_in  in  4*NUM_DIGITS  packed BCD word; nibble k drives digit k; digit NUM_DIGITS-1 is the most significant.
- lz_en  in  1  enables leading-zero blanking.
- blank_all  in  1  blanks the whole display; scanning continues.
- digit_out  out  4  BCD code sent to the decoder; 4'hF means blank (the decoder's default arm).
- dig_sel_n  out  NUM_DIGITS  one-cold digit enables; all ones means no digit is lit.
- frame_done  out  1  one-cycle pulse at the start of each frame.

## Operation
- State
  - prescaler cnt: 0..SCAN_DIV-1.
  - slot index idx: 0..NUM_DIGITS-1.
  - pending buffer pend.
  - active buffer act.
- Prescaler and slot stepping
  - cnt increments every cycle.
  - When cnt==SCAN_DIV-1, cnt wraps to 0 and idx advances.
  - idx wraps from NUM_DIGITS-1 to 0.
- Buffering
  - load=1 writes bcd_in into pend on the next edge.
  - pend is copied to act on the edge that enters slot 0 (idx wraps to 0, cnt=0). This prevents mid-frame tearing.
  - Simultaneous load and frame boundary: bcd_in is written to both pend and act on that edge; the new value is displayed in the same frame.
- Leading-zero blanking
  - Evaluated on act.
  - When lz_en=1, every digit above the most significant nonzero nibble whose value is 0 outputs 4'hF.
  - Digit 0 is never blanked, so all-zero act shows a single "0".
  - Nibble values 10..15 count as nonzero and pass through unchanged; the decoder renders them blank.
- Select generation
  - Slot cycle 0 (cnt==0) is the dead cycle: dig_sel_n is all ones.
  - Cycles 1..SCAN_DIV-1: dig_sel_n[idx]=0 and all other bits are 1.
  - digit_out carries act nibble idx (after blanking) for the whole slot, including the dead cycle.
- blank_all=1
  - Forces dig_sel_n to all ones and digit_out to 4'hF.
  - cnt, idx and buffer transfers proceed normally.
  - Deasserting it mid-slot resumes normal output on the next edge.
- frame_done is high exactly during cycle 0 of slot 0, whether or not blank_all is set.

## Timing
- Outputs are registered. The values shown in any cycle correspond to that cycle's (idx, cnt); there is no extra pipeline offset.
- Reset values, held while rst_n=0:
  - cnt=0, idx=0, pend=0, act=0.
  - digit_out=4'hF, dig_sel_n=all ones, frame_done=0.
- The reset state is cycle 0 of slot 0 with frame_done suppressed. The first edge after release enters cycle 1 of slot 0, where digit 0 is lit showing "0".
- Reset asserted mid-frame immediately forces the reset values; pending data is lost.
- Frame period is NUM_DIGITS*SCAN_DIV cycles. Each digit is lit for SCAN_DIV-1 cycles per frame.
- Load-to-display latency: from 1 cycle (load on a boundary edge) up to NUM_DIGITS*SCAN_DIV cycles.
- Back-to-back loads: the last one before the boundary edge wins.

## Test plan
Bench configuration: NUM_DIGITS=4, SCAN_DIV=4.
- Reset release, no load, lz_en=0 -> digit_out=0 every slot. dig_sel_n follows 1111,1110,1110,1110 then 1111,1101,1101,1101, and so on. frame_done pulses every 16 cycles, first at cycle 16 after release.
- load 16'h1234 mid-frame -> display stays 0000 until the next slot-0 entry. Then slots show 4,3,2,1 on idx 0..3.
- load 16'h0050 with lz_en=1 -> slots 0..3 output 0,5,F,F. With lz_en=0 -> 0,5,0,0.
- load 16'h0000 with lz_en=1 -> slot 0 outputs 0; slots 1..3 output F.
- load 16'h9876 asserted exactly on the boundary edge -> slot 0 of that same frame shows 6.
- blank_all=1 for 2 frames -> dig_sel_n=1111 and digit_out=F throughout, frame_done still pulses at a 16-cycle period. Assert rst_n=0 mid-slot -> outputs return to reset values immediately.

Source files
------------

// File: rtl/display_scan_driver.sv
// display_scan_driver
// Time-multiplexed scan driver feeding a BCD-to-seven-segment decoder.
// Holds a packed BCD word in a pending/active double buffer and steps
// through the digit positions. Each position gets one BCD code and one
// active-low digit-select line. Slot cycle 0 is a dead cycle (no digit lit)
// to suppress ghosting.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   load       one-cycle strobe capturing bcd_in into the pending buffer
//   bcd_in     packed BCD word, nibble k -> digit k (MSD = NUM_DIGITS-1)
//   lz_en      leading-zero blanking enable
//   blank_all  blank whole display (scanning continues)
//   digit_out  BCD code to decoder, 4'hF = blank
//   dig_sel_n  one-cold digit enables, all ones = nothing lit
//   frame_done one-cycle pulse during cycle 0 of slot 0
module display_scan_driver #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SCAN_DIV   = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   bcd_in,
    input  logic                      lz_en,
    input  logic                      blank_all,
    output logic [3:0]                digit_out,
    output logic [NUM_DIGITS-1:0]     dig_sel_n,
    output logic                      frame_done
);

    localparam int unsigned CNT_W  = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
    localparam int unsigned WORD_W = 4 * NUM_DIGITS;

    logic [CNT_W-1:0]      cnt_q,  cnt_d;
    logic [IDX_W-1:0]      idx_q,  idx_d;
    logic [WORD_W-1:0]     pend_q, pend_d;
    logic [WORD_W-1:0]     act_q,  act_d;
    logic [3:0]            digit_q, digit_d;
    logic [NUM_DIGITS-1:0] sel_q,   sel_d;
    logic                  fd_q,    fd_d;

    logic                  slot_end;
    logic                  frame_end;
    logic                  zero_run;
    logic                  lz_blank;
    logic [3:0]            nib;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            pend_q  <= '0;
            act_q   <= '0;
            digit_q <= 4'hF;
            sel_q   <= '1;
            fd_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
            digit_q <= digit_d;
            sel_q   <= sel_d;
            fd_q    <= fd_d;
        end
    end

    // Next state; outputs are computed from the next (idx, cnt, act) so the
    // registered outputs line up with the state they are shown alongside.
    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        pend_d    = pend_q;
        act_d     = act_q;
        digit_d   = 4'hF;
        sel_d     = '1;
        fd_d      = 1'b0;
        zero_run  = 1'b1;
        lz_blank  = 1'b0;
        nib       = 4'h0;

        slot_end  = (cnt_q == CNT_W'(SCAN_DIV - 1));
        frame_end = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));

        if (slot_end) begin
            cnt_d = '0;
            idx_d = frame_end ? '0 : idx_q + IDX_W'(1);
        end

        if (load) begin
            pend_d = bcd_in;
        end

        // A load coinciding with the frame boundary goes straight to act
        if (frame_end) begin
            act_d = pend_d;
        end

        // Walk from the MSD down; zero_run stays set while every digit seen
        // so far (including the current one) is zero.
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (act_d[4*k +: 4] == 4'h0);
            if (IDX_W'(k) == idx_d) begin
                nib      = act_d[4*k +: 4];
                lz_blank = zero_run && (k != 0);
                if (cnt_d != '0) begin
                    sel_d[k] = 1'b0;
                end
            end
        end

        digit_d = (lz_en && lz_blank) ? 4'hF : nib;

        if (blank_all) begin
            digit_d = 4'hF;
            sel_d   = '1;
        end

        fd_d = (cnt_d == '0) && (idx_d == '0);
    end

    assign digit_out  = digit_q;
    assign dig_sel_n  = sel_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver with NUM_DIGITS=4, SCAN_DIV=4
// (16-cycle frames). Table of load scenarios plus hand sequences for boot,
// boundary load, back-to-back loads, blanking and asynchronous reset.
module tb_display_scan_driver;

    localparam int unsigned ND = 4;
    localparam int unsigned SD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] bcd_in;
    logic        lz_en;
    logic        blank_all;
    logic [3:0]  digit_out;
    logic [3:0]  dig_sel_n;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [15:0] val;
        logic        lz;
        logic [15:0] exp;   // nibble i = expected digit_out during slot i
    } vec_t;

    vec_t        tbl[5];
    logic [15:0] prev_exp;
    logic        prev_lz;

    display_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .bcd_in     (bcd_in),
        .lz_en      (lz_en),
        .blank_all  (blank_all),
        .digit_out  (digit_out),
        .dig_sel_n  (dig_sel_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [3:0] ed, input logic [3:0] es, input logic ef);
        checks++;
        if (digit_out !== ed || dig_sel_n !== es || frame_done !== ef) begin
            failures++;
            $display("FAIL %s cyc=%0d got digit=%h sel=%b fd=%b want digit=%h sel=%b fd=%b",
                     nm, cyc, digit_out, dig_sel_n, frame_done, ed, es, ef);
        end
    endtask

    function automatic logic [3:0] sel_at(input int c);
        int         p;
        logic [3:0] s;
        p = c % 16;
        s = 4'hF;
        if (p % 4 != 0) s[p/4] = 1'b0;
        return s;
    endfunction

    function automatic logic [3:0] nib(input logic [15:0] w, input int i);
        logic [15:0] t;
        t = w >> (4 * i);
        return t[3:0];
    endfunction

    task automatic chk_frame(input string nm, input logic [15:0] e);
        chk(nm, nib(e, (cyc % 16) / 4), sel_at(cyc), (cyc % 16) == 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        load      = 1'b0;
        bcd_in    = 16'h0000;
        lz_en     = 1'b0;
        blank_all = 1'b0;

        tbl[0] = '{16'h1234, 1'b0, 16'h1234};
        tbl[1] = '{16'h0050, 1'b0, 16'h0050};
        tbl[2] = '{16'h0050, 1'b1, 16'hFF50};
        tbl[3] = '{16'h0000, 1'b1, 16'hFFF0};
        tbl[4] = '{16'hF0A0, 1'b1, 16'hF0A0};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;

        // Reset state, then first frame of zeros, then first frame_done
        chk("reset", 4'hF, 4'hF, 1'b0);
        for (int c = 1; c < 16; c++) begin
            step();
            chk("boot", 4'h0, sel_at(cyc), 1'b0);
        end
        step();
        chk("boot_fd", 4'h0, 4'hF, 1'b1);

        // Mid-frame loads: old value held until boundary, then new frame
        prev_exp = 16'h0000;
        prev_lz  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            while (cyc % 16 != 5) step();
            load   = 1'b1;
            bcd_in = tbl[i].val;
            lz_en  = tbl[i].lz;
            step();
            load   = 1'b0;
            bcd_in = 16'hDEAD;
            while (cyc % 16 != 0) begin
                if (tbl[i].lz == prev_lz) chk_frame("hold", prev_exp);
                step();
            end
            for (int c = 0; c < 16; c++) begin
                chk_frame("case", tbl[i].exp);
                step();
            end
            prev_exp = tbl[i].exp;
            prev_lz  = tbl[i].lz;
        end

        // Load on the boundary edge is shown in that same frame
        while (cyc % 16 != 15) step();
        load   = 1'b1;
        bcd_in = 16'h9876;
        step();
        load   = 1'b0;
        bcd_in = 16'h0000;
        for (int c = 0; c < 16; c++) begin
            chk_frame("bnd", 16'h9876);
            step();
        end

        // Back-to-back loads: the later one wins
        while (cyc % 16 != 5) step();
        load   = 1'b1;
        bcd_in = 16'h1111;
        step();
        bcd_in = 16'h2222;
        step();
        load   = 1'b0;
        bcd_in = 16'h0000;
        while (cyc % 16 != 0) step();
        for (int c = 0; c < 16; c++) begin
            chk_frame("b2b", 16'h2222);
            step();
        end

        // Two blanked frames; frame_done keeps pulsing
        blank_all = 1'b1;
        for (int c = 0; c < 32; c++) begin
            step();
            chk("blank", 4'hF, 4'hF, (cyc % 16) == 0);
        end
        step();
        chk("blank_tail", 4'hF, 4'hF, 1'b0);
        blank_all = 1'b0;
        step();
        chk("unblank", 4'h2, 4'b1110, 1'b0);

        // Asynchronous reset mid-slot
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", 4'hF, 4'hF, 1'b0);
        step();
        chk("rst_hold", 4'hF, 4'hF, 1'b0);
        rst_n = 1'b1;
        cyc   = 0;
        step();
        chk("rst_rel", 4'h0, 4'b1110, 1'b0);
        while (cyc % 16 != 0) step();
        chk("rst_lost", 4'h0, 4'hF, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
